// File: rtl/bitty_fetch_unit.sv
// Instruction fetch unit for the BittyPro control unit.
// Owns the PC, fetches 16-bit words, holds inst stable for the decoder, and
// prefetches one word during execution so consecutive instructions issue with
// no bubble. Fetching HALT_INST stops the unit until reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped, waiting for run
// S_REQ   | one-cycle read strobe for the word at pc
// S_WAIT  | read outstanding, no instruction under execution
// S_EXEC  | decoder executing inst; one prefetch may be in flight/buffered
// S_DRAIN | run dropped with a read in flight; swallow the return
// S_HALT  | HALT_INST fetched; sticky until reset
module bitty_fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [15:0]        HALT_INST = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic [15:0]       inst_o,
  output logic              inst_valid_o,
  output logic              cu_hold_o,
  input  logic              done_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic [15:0]       retired_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_EXEC, S_DRAIN, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                halted_q, halted_d;
  logic [15:0]         retired_q, retired_d;
  logic                pf_valid_q, pf_valid_d;
  logic [15:0]         pf_buf_q, pf_buf_d;
  logic [ADDR_W-1:0]   pf_addr_q, pf_addr_d;
  logic                pf_issued_q, pf_issued_d;
  logic                rd_out_q, rd_out_d;

  logic                rv;
  logic                issue;
  logic                take;
  logic [15:0]         nxt_word;

  // A return only counts when we actually have a read in flight.
  assign rv = mem_rvalid_i & rd_out_q;

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    retired_d    = retired_q;
    pf_valid_d   = pf_valid_q;
    pf_buf_d     = pf_buf_q;
    pf_addr_d    = pf_addr_q;
    pf_issued_d  = pf_issued_q;
    rd_out_d     = rd_out_q;
    mem_rd_o     = 1'b0;
    mem_addr_o   = '0;
    issue        = 1'b0;
    take         = pf_valid_q | rv;
    nxt_word     = pf_valid_q ? pf_buf_q : mem_rdata_i;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_REQ;
      end

      S_REQ: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
        rd_out_d   = 1'b1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (rv) begin
          rd_out_d = 1'b0;
          if (mem_rdata_i == HALT_INST) begin
            halted_d     = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = S_HALT;
          end else begin
            inst_d       = mem_rdata_i;
            inst_valid_d = 1'b1;
            pf_valid_d   = 1'b0;
            pf_issued_d  = 1'b0;
            state_d      = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        // Only one prefetch per instruction; pf_addr remembers where it came
        // from so a stop can rewind the PC and refetch it later.
        issue = run_i & ~pf_valid_q & ~rd_out_q & ~pf_issued_q;
        if (issue) begin
          mem_rd_o    = 1'b1;
          mem_addr_o  = pc_q;
          pc_d        = pc_q + ADDR_W'(1);
          pf_addr_d   = pc_q;
          pf_issued_d = 1'b1;
          rd_out_d    = 1'b1;
        end
        if (rv) begin
          pf_valid_d = 1'b1;
          pf_buf_d   = mem_rdata_i;
          rd_out_d   = 1'b0;
        end
        if (done_i) begin
          retired_d = retired_q + 16'd1;
          if (!run_i) begin
            if (pf_issued_q) pc_d = pf_addr_q;
            pf_valid_d   = 1'b0;
            pf_issued_d  = 1'b0;
            inst_valid_d = 1'b0;
            state_d      = (rd_out_q && !rv) ? S_DRAIN : S_IDLE;
          end else if (take) begin
            // Buffered word, or the return arriving this very cycle.
            pf_valid_d  = 1'b0;
            pf_issued_d = 1'b0;
            if (nxt_word == HALT_INST) begin
              inst_valid_d = 1'b0;
              halted_d     = 1'b1;
              state_d      = S_HALT;
            end else begin
              inst_d = nxt_word;
            end
          end else if (rd_out_q || issue) begin
            pf_issued_d  = 1'b0;
            inst_valid_d = 1'b0;
            state_d      = S_WAIT;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
      end

      S_DRAIN: begin
        if (rv) begin
          rd_out_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_HALT: begin
        inst_valid_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      retired_q    <= '0;
      pf_valid_q   <= 1'b0;
      pf_buf_q     <= '0;
      pf_addr_q    <= '0;
      pf_issued_q  <= 1'b0;
      rd_out_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      retired_q    <= retired_d;
      pf_valid_q   <= pf_valid_d;
      pf_buf_q     <= pf_buf_d;
      pf_addr_q    <= pf_addr_d;
      pf_issued_q  <= pf_issued_d;
      rd_out_q     <= rd_out_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign cu_hold_o    = ~inst_valid_q;
  assign pc_o         = pc_q;
  assign halted_o     = halted_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed testbench for bitty_fetch_unit. A second instance with
// RESET_PC=8'hFF exercises PC wrap with hand-driven memory returns.
module tb_bitty_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run, done, rvalid;
  logic [15:0] rdata;
  logic        mem_rd, inst_valid, cu_hold, halted;
  logic [7:0]  mem_addr, pc;
  logic [15:0] inst, retired;

  logic        run_w, done_w, rvalid_w;
  logic [15:0] rdata_w;
  logic        mem_rd_w, inst_valid_w, cu_hold_w, halted_w;
  logic [7:0]  mem_addr_w, pc_w;
  logic [15:0] inst_w, retired_w;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  int          lat;
  bit          req;
  logic [7:0]  req_addr;
  bit          pend_active;
  int          pend_cnt;
  logic [7:0]  pend_addr;
  int          rd_count;

  bitty_fetch_unit dut (
    .clk(clk), .reset(reset), .run_i(run),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_rdata_i(rdata), .mem_rvalid_i(rvalid),
    .inst_o(inst), .inst_valid_o(inst_valid), .cu_hold_o(cu_hold),
    .done_i(done), .pc_o(pc), .halted_o(halted), .retired_o(retired)
  );

  bitty_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_w (
    .clk(clk), .reset(reset), .run_i(run_w),
    .mem_rd_o(mem_rd_w), .mem_addr_o(mem_addr_w),
    .mem_rdata_i(rdata_w), .mem_rvalid_i(rvalid_w),
    .inst_o(inst_w), .inst_valid_o(inst_valid_w), .cu_hold_o(cu_hold_w),
    .done_i(done_w), .pc_o(pc_w), .halted_o(halted_w), .retired_o(retired_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: capture strobes at the edge, return after lat cycles.
  always @(posedge clk) begin
    if (mem_rd) begin
      req      = 1'b1;
      req_addr = mem_addr;
      rd_count = rd_count + 1;
    end
  end

  always @(negedge clk) begin
    rvalid = 1'b0;
    if (req) begin
      req         = 1'b0;
      pend_active = 1'b1;
      pend_cnt    = lat;
      pend_addr   = req_addr;
    end
    if (pend_active) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        rvalid      = 1'b1;
        rdata       = mem[pend_addr];
        pend_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; done = 1'b0;
    run_w = 1'b0; done_w = 1'b0; rvalid_w = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_rd(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (mem_rd) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (inst_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
    total++; if (cu_hold !== 1'b1) begin bad++; $display("FAIL reset_cu_hold: got %b want 1", cu_hold); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    total++; if (inst !== 16'h0000) begin bad++; $display("FAIL reset_inst: got %h want 0000", inst); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    total++; if (retired !== 16'h0000) begin bad++; $display("FAIL reset_retired: got %h want 0000", retired); end
    total++; if (mem_rd !== 1'b0 || mem_addr !== 8'h00) begin bad++; $display("FAIL reset_mem: got rd=%b addr=%h want rd=0 addr=00", mem_rd, mem_addr); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    mem[0] = 16'h2404; mem[1] = 16'h1111; mem[2] = 16'h2222;
    lat = 2;
    run = 1'b1;
    wait_rd(10, ok);
    total++; if (!ok || mem_addr !== 8'h00) begin bad++; $display("FAIL single_req: got ok=%b addr=%h want ok=1 addr=00", ok, mem_addr); end
    wait_valid(10, ok);
    total++; if (!ok || inst !== 16'h2404) begin bad++; $display("FAIL single_inst: got ok=%b inst=%h want ok=1 inst=2404", ok, inst); end
    total++; if (cu_hold !== 1'b0) begin bad++; $display("FAIL single_cu_hold: got %b want 0", cu_hold); end
    total++; if (mem_rd !== 1'b1 || mem_addr !== 8'h01) begin bad++; $display("FAIL single_prefetch: got rd=%b addr=%h want rd=1 addr=01", mem_rd, mem_addr); end
    repeat (5) tick();
    total++; if (inst !== 16'h2404 || retired !== 16'h0000) begin bad++; $display("FAIL single_stable: got inst=%h ret=%h want inst=2404 ret=0000", inst, retired); end
    pulse_done();
    total++; if (retired !== 16'h0001) begin bad++; $display("FAIL single_retired: got %h want 0001", retired); end
    total++; if (inst !== 16'h1111 || inst_valid !== 1'b1) begin bad++; $display("FAIL single_next: got inst=%h v=%b want inst=1111 v=1", inst, inst_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rc;
    do_reset();
    mem[0] = 16'h2404; mem[1] = 16'h4808; mem[2] = 16'hFFFF;
    lat = 1;
    rd_count = 0;
    run = 1'b1;
    wait_valid(10, ok);
    total++; if (!ok || inst !== 16'h2404) begin bad++; $display("FAIL b2b_first: got ok=%b inst=%h want ok=1 inst=2404", ok, inst); end
    repeat (3) tick();
    pulse_done();
    total++; if (inst !== 16'h4808 || inst_valid !== 1'b1) begin bad++; $display("FAIL b2b_second: got inst=%h v=%b want inst=4808 v=1", inst, inst_valid); end
    repeat (3) tick();
    pulse_done();
    total++; if (halted !== 1'b1 || inst_valid !== 1'b0 || cu_hold !== 1'b1) begin bad++; $display("FAIL b2b_halt: got h=%b v=%b hold=%b want h=1 v=0 hold=1", halted, inst_valid, cu_hold); end
    total++; if (retired !== 16'h0002) begin bad++; $display("FAIL b2b_retired: got %h want 0002", retired); end
    rc = rd_count;
    repeat (6) begin
      done = 1'b1;
      tick();
    end
    done = 1'b0;
    total++; if (rd_count !== 3 || rc !== 3) begin bad++; $display("FAIL b2b_no_reads: got %0d then %0d want 3", rc, rd_count); end
    total++; if (retired !== 16'h0002 || halted !== 1'b1) begin bad++; $display("FAIL b2b_halt_sticky: got ret=%h h=%b want ret=0002 h=1", retired, halted); end
  endtask

  task automatic test_stop();
    bit ok;
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    lat = 3;
    run = 1'b1;
    wait_valid(12, ok);
    total++; if (!ok || inst !== 16'h1000) begin bad++; $display("FAIL stop_first: got ok=%b inst=%h want ok=1 inst=1000", ok, inst); end
    for (int k = 1; k <= 3; k++) begin
      repeat (6) tick();
      pulse_done();
    end
    total++; if (inst !== 16'h1003 || mem_rd !== 1'b1 || mem_addr !== 8'h04) begin bad++; $display("FAIL stop_pf4: got inst=%h rd=%b addr=%h want inst=1003 rd=1 addr=04", inst, mem_rd, mem_addr); end
    tick();
    run = 1'b0;
    pulse_done();
    total++; if (inst_valid !== 1'b0 || pc !== 8'h04 || retired !== 16'h0004) begin bad++; $display("FAIL stop_done: got v=%b pc=%h ret=%h want v=0 pc=04 ret=0004", inst_valid, pc, retired); end
    repeat (6) tick();
    total++; if (inst_valid !== 1'b0 || inst !== 16'h1003 || mem_rd !== 1'b0 || pc !== 8'h04) begin bad++; $display("FAIL stop_drain: got v=%b inst=%h rd=%b pc=%h want v=0 inst=1003 rd=0 pc=04", inst_valid, inst, mem_rd, pc); end
    run = 1'b1;
    wait_rd(10, ok);
    total++; if (!ok || mem_addr !== 8'h04) begin bad++; $display("FAIL stop_restart: got ok=%b addr=%h want ok=1 addr=04", ok, mem_addr); end
    wait_valid(12, ok);
    total++; if (!ok || inst !== 16'h1004) begin bad++; $display("FAIL stop_resume: got ok=%b inst=%h want ok=1 inst=1004", ok, inst); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    total++; if (pc_w !== 8'hFF) begin bad++; $display("FAIL wrap_reset_pc: got %h want ff", pc_w); end
    run_w = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd_w) begin ok = 1'b1; break; end
    end
    total++; if (!ok || mem_addr_w !== 8'hFF) begin bad++; $display("FAIL wrap_req_ff: got ok=%b addr=%h want ok=1 addr=ff", ok, mem_addr_w); end
    tick();
    rvalid_w = 1'b1; rdata_w = 16'h0010;
    tick();
    rvalid_w = 1'b0;
    total++; if (inst_w !== 16'h0010 || inst_valid_w !== 1'b1) begin bad++; $display("FAIL wrap_inst_ff: got inst=%h v=%b want inst=0010 v=1", inst_w, inst_valid_w); end
    total++; if (mem_rd_w !== 1'b1 || mem_addr_w !== 8'h00 || pc_w !== 8'h00) begin bad++; $display("FAIL wrap_pf_00: got rd=%b addr=%h pc=%h want rd=1 addr=00 pc=00", mem_rd_w, mem_addr_w, pc_w); end
    tick();
    rvalid_w = 1'b1; rdata_w = 16'h0020;
    tick();
    rvalid_w = 1'b0;
    total++; if (pc_w !== 8'h01) begin bad++; $display("FAIL wrap_pc_01: got %h want 01", pc_w); end
    done_w = 1'b1;
    tick();
    done_w = 1'b0;
    total++; if (inst_w !== 16'h0020 || retired_w !== 16'h0001) begin bad++; $display("FAIL wrap_inst_00: got inst=%h ret=%h want inst=0020 ret=0001", inst_w, retired_w); end
    run_w = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    mem[0] = 16'hABCD;
    lat = 4;
    run = 1'b1;
    wait_rd(10, ok);
    total++; if (!ok || mem_addr !== 8'h00) begin bad++; $display("FAIL midwait_req: got ok=%b addr=%h want ok=1 addr=00", ok, mem_addr); end
    tick();
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    total++; if (inst !== 16'h0000 || inst_valid !== 1'b0 || cu_hold !== 1'b1) begin bad++; $display("FAIL midwait_ignore: got inst=%h v=%b hold=%b want inst=0000 v=0 hold=1", inst, inst_valid, cu_hold); end
    total++; if (mem_rd !== 1'b0 || pc !== 8'h00) begin bad++; $display("FAIL midwait_idle: got rd=%b pc=%h want rd=0 pc=00", mem_rd, pc); end
    run = 1'b1;
    wait_rd(10, ok);
    total++; if (!ok || mem_addr !== 8'h00) begin bad++; $display("FAIL midwait_restart: got ok=%b addr=%h want ok=1 addr=00", ok, mem_addr); end
    wait_valid(12, ok);
    total++; if (!ok || inst !== 16'hABCD) begin bad++; $display("FAIL midwait_fetch: got ok=%b inst=%h want ok=1 inst=abcd", ok, inst); end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; done = 1'b0;
    run_w = 1'b0; done_w = 1'b0; rvalid_w = 1'b0; rdata_w = '0;
    rvalid = 1'b0; rdata = '0;
    req = 1'b0; pend_active = 1'b0; pend_cnt = 0; rd_count = 0; lat = 1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset();
    test_stop();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
